// File: rtl/alu_pkg.sv
// Shared EX-stage definitions: datapath widths, ALU op codes and mul/div FSM states.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;
  localparam int unsigned CNTW = $clog2(XLEN);

  localparam logic [OPW-1:0] ALU_ADD   = OPW'(0);
  localparam logic [OPW-1:0] ALU_SUB   = OPW'(1);
  localparam logic [OPW-1:0] ALU_AND   = OPW'(2);
  localparam logic [OPW-1:0] ALU_OR    = OPW'(3);
  localparam logic [OPW-1:0] ALU_SLT   = OPW'(4);
  localparam logic [OPW-1:0] ALU_XOR   = OPW'(5);
  localparam logic [OPW-1:0] ALU_NOR   = OPW'(6);
  localparam logic [OPW-1:0] ALU_SLL   = OPW'(7);
  localparam logic [OPW-1:0] ALU_SRL   = OPW'(8);
  localparam logic [OPW-1:0] ALU_SRA   = OPW'(9);
  localparam logic [OPW-1:0] ALU_MULT  = OPW'(10);
  localparam logic [OPW-1:0] ALU_MULTU = OPW'(11);
  localparam logic [OPW-1:0] ALU_DIV   = OPW'(12);
  localparam logic [OPW-1:0] ALU_DIVU  = OPW'(13);
  localparam logic [OPW-1:0] ALU_MFHI  = OPW'(14);
  localparam logic [OPW-1:0] ALU_MFLO  = OPW'(15);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply / restoring divide with HI/LO registers, one step per cycle.
// Divider datapath is present only when EX_DIV_EN is defined; otherwise DIV/DIVU are ignored.
module muldiv_iter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy
);

  md_state_t         state, state_nxt;
  logic [CNTW-1:0]   cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic              neg_lo;
  logic              sgn;
  logic              go_mul;
  logic              go_div;

  assign sgn    = (op == ALU_MULT) || (op == ALU_DIV);
  assign go_mul = start && ((op == ALU_MULT) || (op == ALU_MULTU));
  assign mag_a  = (sgn && a[XLEN-1]) ? -a : a;
  assign mag_b  = (sgn && b[XLEN-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign prod_fix = neg_lo ? -acc : acc;

`ifdef EX_DIV_EN
  logic          md_div;
  logic          neg_hi;
  logic [XLEN:0] div_sh;
  logic          div_ge;
  logic [XLEN-1:0] div_rem;

  assign go_div  = start && ((op == ALU_DIV) || (op == ALU_DIVU));
  // Divide: acc = {partial remainder, dividend bits shifting into quotient}
  assign div_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge  = div_sh >= {1'b0, opnd};
  assign div_rem = div_ge ? XLEN'(div_sh - {1'b0, opnd}) : div_sh[XLEN-1:0];
`else
  assign go_div  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: begin
        if (go_mul)      state_nxt = MD_MUL;
        else if (go_div) state_nxt = MD_DIV;
      end
      MD_MUL, MD_DIV: if (cnt == CNTW'(XLEN-1)) state_nxt = MD_DONE;
      default:        state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
`ifdef EX_DIV_EN
      md_div <= 1'b0;
      neg_hi <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt != MD_IDLE);
      case (state)
        MD_IDLE: begin
          if (go_mul || go_div) begin
            cnt    <= '0;
            opnd   <= mag_b;
            acc    <= {{XLEN{1'b0}}, mag_a};
            neg_lo <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
`ifdef EX_DIV_EN
            neg_hi <= sgn && a[XLEN-1];
            md_div <= go_div;
`endif
          end
        end
        MD_MUL: begin
          cnt <= cnt + CNTW'(1);
          acc <= {mul_sum, acc[XLEN-1:1]};
        end
`ifdef EX_DIV_EN
        MD_DIV: begin
          cnt <= cnt + CNTW'(1);
          acc <= {div_rem, acc[XLEN-2:0], div_ge};
        end
`endif
        MD_DONE: begin
`ifdef EX_DIV_EN
          if (md_div) begin
            // Zero divisor leaves remainder = |dividend|; sign restore yields the dividend
            hi <= neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            lo <= (opnd == '0) ? '1 : (neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
          end else
`endif
          {hi, lo} <= prod_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_alu_stage.sv
// EX-stage execute unit: ALU mux, HI/LO hazard stall and EX/MEM pipeline register.
// Optional EX_DIV_EN enables the iterative divider inside muldiv_iter.
module ex_alu_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      shamt,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall_req,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [4:0]      mem_rd,
  output logic            md_busy
);

  logic            hilo_op;
  logic            md_op;
  logic            issue;
  logic            slt_res;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] alu_res;

  assign hilo_op   = (alu_op >= ALU_MULT) && (alu_op <= ALU_MFLO);
  assign md_op     = hilo_op && (alu_op <= ALU_DIVU);
  assign stall_req = ex_valid && !flush && md_busy && hilo_op;
  assign issue     = ex_valid && !flush && !stall_req;
  assign slt_res   = $signed(src_a) < $signed(src_b);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt_res};
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_NOR:  alu_res = ~(src_a | src_b);
      ALU_SLL:  alu_res = src_b << shamt;
      ALU_SRL:  alu_res = src_b >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(src_b) >>> shamt);
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  muldiv_iter u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (issue && md_op),
    .op    (alu_op),
    .a     (src_a),
    .b     (src_b),
    .hi    (hi),
    .lo    (lo),
    .busy  (md_busy)
  );

  // Mul/div issue occupies the slot but never writes a GPR
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      mem_result <= '0;
      mem_rd     <= '0;
    end else begin
      mem_valid <= issue;
      if (issue) begin
        mem_result <= md_op ? '0 : alu_res;
        mem_rd     <= md_op ? 5'd0 : rd_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Randomized and directed checks of ex_alu_stage against an arithmetic reference model.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  alu_op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic [4:0]  rd_in = '0;
  logic        stall_req, mem_valid, md_busy;
  logic [31:0] mem_result;
  logic [4:0]  mem_rd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int md_end  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  ex_alu_stage dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .alu_op     (alu_op),
    .src_a      (src_a),
    .src_b      (src_b),
    .shamt      (shamt),
    .rd_in      (rd_in),
    .flush      (flush),
    .stall_req  (stall_req),
    .mem_valid  (mem_valid),
    .mem_result (mem_result),
    .mem_rd     (mem_rd),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit sets_busy(input int op);
`ifdef EX_DIV_EN
    return (op >= 10) && (op <= 13);
`else
    return (op == 10) || (op == 11);
`endif
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh);
    logic [63:0] ext;
    int ia, ib;
    ia  = a;
    ib  = b;
    ext = {{32{b[31]}}, b};
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return (ia < ib) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return ~(a | b);
      7:  return b << sh;
      8:  return b >> sh;
      9:  begin ext = ext >> sh; return ext[31:0]; end
      14: return m_hi;
      15: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic apply_md(input int op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint unsigned pu;
    int ia, ib;
    ia = a;
    ib = b;
    case (op)
      10: begin p = longint'(ia) * longint'(ib); {m_hi, m_lo} = p; end
      11: begin pu = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = pu; end
`ifdef EX_DIV_EN
      12: begin
        if (b == 32'd0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = '0; end
        else begin m_lo = ia / ib; m_hi = ia % ib; end
      end
      13: begin
        if (b == 32'd0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
`endif
      default: ;
    endcase
  endtask

  // Called at a negedge; presents one instruction, waits out any stall, checks EX/MEM.
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] rd);
    int first_pe, stalls, exp_stall;
    logic [31:0] exp_res;
    bit hilo, mdop;
    hilo = (op >= 10) && (op <= 15);
    mdop = (op >= 10) && (op <= 13);
    ex_valid = 1'b1; flush = 1'b0;
    alu_op = 6'(op); src_a = a; src_b = b; shamt = sh; rd_in = rd;
    first_pe = cyc + 1;
    stalls = 0;
    #1;
    while (stall_req && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    exp_stall = (hilo && md_end > first_pe) ? md_end - first_pe : 0;
    check($sformatf("stall_cycles op%0d", op), 32'(stalls), 32'(exp_stall));
    exp_res = ref_alu(op, a, b, sh);
    if (sets_busy(op)) md_end = cyc + 1 + 34;
    apply_md(op, a, b);
    @(negedge clk);
    ex_valid = 1'b0;
    check($sformatf("mem_valid op%0d", op), 32'(mem_valid), 32'd1);
    check($sformatf("mem_rd op%0d", op), 32'(mem_rd), mdop ? 32'd0 : 32'(rd));
    if (!mdop) check($sformatf("mem_result op%0d", op), mem_result, exp_res);
    if (mdop) check($sformatf("md_busy op%0d", op), 32'(md_busy), 32'(sets_busy(op)));
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 10));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int op, r;
    repeat (3) @(negedge clk);
    check("rst mem_valid", 32'(mem_valid), 32'd0);
    check("rst mem_result", mem_result, 32'd0);
    check("rst mem_rd", 32'(mem_rd), 32'd0);
    check("rst md_busy", 32'(md_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd3);
    check("add wrap", mem_result, 32'h8000_0000);
    do_op(9, 32'd0, 32'h8000_0000, 5'd4, 5'd4);
    check("sra", mem_result, 32'hF800_0000);
    do_op(4, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd5);
    check("slt", mem_result, 32'd1);
    do_op(6, 32'd0, 32'd0, 5'd0, 5'd6);
    check("nor", mem_result, 32'hFFFF_FFFF);

    do_op(10, 32'hFFFF_FFFD, 32'd5, 5'd0, 5'd7);
    do_op(15, 32'd0, 32'd0, 5'd0, 5'd8);
    check("mult mflo", mem_result, 32'hFFFF_FFF1);
    do_op(14, 32'd0, 32'd0, 5'd0, 5'd9);
    check("mult mfhi", mem_result, 32'hFFFF_FFFF);

    // Flush a live add
    ex_valid = 1'b1; flush = 1'b1; alu_op = 6'd0; src_a = 32'd1; src_b = 32'd2; rd_in = 5'd10;
    @(negedge clk);
    check("flush add mem_valid", 32'(mem_valid), 32'd0);

    // Flush while a multiply is iterating must not disturb it
    flush = 1'b0; ex_valid = 1'b0;
    do_op(11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 5'd11);
    ex_valid = 1'b1; flush = 1'b1; alu_op = 6'd15;
    #1;
    check("flush no stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    check("flush mflo mem_valid", 32'(mem_valid), 32'd0);
    flush = 1'b0; ex_valid = 1'b0;
    do_op(15, 32'd0, 32'd0, 5'd0, 5'd12);
    do_op(14, 32'd0, 32'd0, 5'd0, 5'd13);

`ifdef EX_DIV_EN
    do_op(12, 32'd7, 32'd0, 5'd0, 5'd1);
    do_op(15, 32'd0, 32'd0, 5'd0, 5'd2);
    check("div0 lo", mem_result, 32'hFFFF_FFFF);
    do_op(14, 32'd0, 32'd0, 5'd0, 5'd2);
    check("div0 hi", mem_result, 32'd7);
    do_op(12, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 5'd1);
    do_op(15, 32'd0, 32'd0, 5'd0, 5'd2);
    check("divovf lo", mem_result, 32'h8000_0000);
    do_op(14, 32'd0, 32'd0, 5'd0, 5'd2);
    check("divovf hi", mem_result, 32'd0);
`else
    do_op(13, 32'd100, 32'd7, 5'd0, 5'd1);
    do_op(15, 32'd0, 32'd0, 5'd0, 5'd2);
`endif

    // Reset in the middle of a multiply aborts it and clears HI/LO
    do_op(10, 32'd1234, 32'd5678, 5'd0, 5'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1; ex_valid = 1'b1; alu_op = 6'd0;
    @(negedge clk);
    check("rst mid md_busy", 32'(md_busy), 32'd0);
    check("rst mid mem_valid", 32'(mem_valid), 32'd0);
    rst = 1'b0; ex_valid = 1'b0;
    m_hi = '0; m_lo = '0; md_end = 0;
    do_op(14, 32'd0, 32'd0, 5'd0, 5'd3);
    do_op(15, 32'd0, 32'd0, 5'd0, 5'd4);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      op = $urandom_range(0, 9);
      else if (r < 7) op = $urandom_range(16, 63);
      else            op = $urandom_range(10, 15);
      do_op(op, rnd_val(), rnd_val(), 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
